fifo_ctrl_udp_loop: RTL and testbench



---
 rtl/fifo_ctrl_udp_loop_pkg.sv | 19 +
 rtl/fifo_ctrl_udp_loop_if.sv | 44 ++++
 rtl/fifo_ptr_udp_loop.sv | 18 +
 rtl/fifo_ctrl_udp_loop.sv | 115 +++++++++++
 tb/tb_fifo_ctrl_udp_loop.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_ctrl_udp_loop_pkg.sv
// Shared sizing helpers and level defaults for the UDP loopback FIFO controller.
package fifo_ctrl_udp_loop_pkg;

    localparam int AE_DEFAULT = 2;

    // One extra MSB distinguishes full from empty when the low bits match.
    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    function automatic int af_default(input int addr_width);
        return fifo_depth(addr_width) - 2;
    endfunction

endpackage

// File: rtl/fifo_ctrl_udp_loop_if.sv
// Request/status bundle between the FIFO user and the controller.
// FIFO_CTRL_ERR_FLAG_EN adds the sticky overflow/underflow flags.
interface fifo_ctrl_udp_loop_if
    import fifo_ctrl_udp_loop_pkg::*;
#(
    parameter int ADDR_WIDTH = 4
);
    localparam int PW = ptr_width(ADDR_WIDTH);

    logic                  wr_en;
    logic                  rd_en;
    logic                  ram_wr_en;
    logic [ADDR_WIDTH-1:0] ram_wr_addr;
    logic [ADDR_WIDTH-1:0] ram_rd_addr;
    logic                  rd_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [PW-1:0]         count;
`ifdef FIFO_CTRL_ERR_FLAG_EN
    logic                  overflow_err;
    logic                  underflow_err;
`endif

    modport master (
        output wr_en, rd_en,
`ifdef FIFO_CTRL_ERR_FLAG_EN
        input  overflow_err, underflow_err,
`endif
        input  ram_wr_en, ram_wr_addr, ram_rd_addr, rd_valid,
        input  full, empty, almost_full, almost_empty, count
    );

    modport slave (
        input  wr_en, rd_en,
`ifdef FIFO_CTRL_ERR_FLAG_EN
        output overflow_err, underflow_err,
`endif
        output ram_wr_en, ram_wr_addr, ram_rd_addr, rd_valid,
        output full, empty, almost_full, almost_empty, count
    );

endinterface

// File: rtl/fifo_ptr_udp_loop.sv
// Wrapping FIFO pointer: advances by one per accepted operation, modulo 2**PW.
module fifo_ptr_udp_loop #(
    parameter int PW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (inc)
            ptr <= ptr + PW'(1);
    end

endmodule

// File: rtl/fifo_ctrl_udp_loop.sv
// FIFO controller for the UDP loopback buffer: pointers, occupancy, flags and read-valid timing.
// Define FIFO_CTRL_ERR_FLAG_EN to add sticky overflow_err/underflow_err outputs.
module fifo_ctrl_udp_loop
    import fifo_ctrl_udp_loop_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int OUT_REG    = 0,
    parameter int AF_LEVEL   = af_default(ADDR_WIDTH),
    parameter int AE_LEVEL   = AE_DEFAULT
) (
    input logic                clk,
    input logic                rst,
    fifo_ctrl_udp_loop_if.slave bus
);

    localparam int            PW   = ptr_width(ADDR_WIDTH);
    localparam logic [PW-1:0] AF_C = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_C = PW'(AE_LEVEL);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] count_q;
    logic [PW-1:0] count_next;
    logic          empty_q;
    logic          af_q;
    logic          ae_q;
    logic          full_w;
    logic          wr_acc;
    logic          rd_acc;

    assign full_w = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                    (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);

    // A reset cycle accepts nothing, so a request during rst never reaches the RAM.
    assign wr_acc = bus.wr_en & ~full_w & ~rst;
    assign rd_acc = bus.rd_en & ~empty_q & ~rst;

    fifo_ptr_udp_loop #(.PW(PW)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (wr_acc),
        .ptr (wr_ptr)
    );

    fifo_ptr_udp_loop #(.PW(PW)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (rd_acc),
        .ptr (rd_ptr)
    );

    always_comb begin
        count_next = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_next = count_q + PW'(1);
            2'b01:   count_next = count_q - PW'(1);
            default: count_next = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            empty_q <= 1'b1;
            af_q    <= (AF_LEVEL == 0);
            ae_q    <= 1'b1;
        end else begin
            count_q <= count_next;
            empty_q <= (count_next == '0);
            af_q    <= (count_next >= AF_C);
            ae_q    <= (count_next <= AE_C);
        end
    end

    generate
        if (OUT_REG == 0) begin : g_show_ahead
            assign bus.rd_valid = rd_acc;
        end else begin : g_out_reg
            logic rd_valid_q;
            always_ff @(posedge clk) begin
                if (rst)
                    rd_valid_q <= 1'b0;
                else
                    rd_valid_q <= rd_acc;
            end
            assign bus.rd_valid = rd_valid_q;
        end
    endgenerate

`ifdef FIFO_CTRL_ERR_FLAG_EN
    logic ovf_q;
    logic unf_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_q | (bus.wr_en & full_w);
            unf_q <= unf_q | (bus.rd_en & empty_q);
        end
    end
    assign bus.overflow_err  = ovf_q;
    assign bus.underflow_err = unf_q;
`endif

    assign bus.ram_wr_en    = wr_acc;
    assign bus.ram_wr_addr  = wr_ptr[ADDR_WIDTH-1:0];
    assign bus.ram_rd_addr  = rd_ptr[ADDR_WIDTH-1:0];
    assign bus.full         = full_w;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;
    assign bus.count        = count_q;

endmodule

// File: tb/tb_fifo_ctrl_udp_loop.sv
// Bench for fifo_ctrl_udp_loop: show-ahead and registered-read instances share one stimulus,
// each backed by a small RAM model and checked against a queue-based FIFO reference.
module tb_fifo_ctrl_udp_loop;
    import fifo_ctrl_udp_loop_pkg::*;

    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_ctrl_udp_loop_if #(.ADDR_WIDTH(4)) bus0 ();
    fifo_ctrl_udp_loop_if #(.ADDR_WIDTH(4)) bus1 ();

    fifo_ctrl_udp_loop #(.ADDR_WIDTH(4), .OUT_REG(0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    fifo_ctrl_udp_loop #(.ADDR_WIDTH(4), .OUT_REG(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    logic [7:0] wdata;
    logic [7:0] mem0 [DEPTH];
    logic [7:0] mem1 [DEPTH];
    logic [7:0] rdata1;

    always @(posedge clk) begin
        if (bus0.ram_wr_en) mem0[bus0.ram_wr_addr] <= wdata;
        if (bus1.ram_wr_en) mem1[bus1.ram_wr_addr] <= wdata;
        rdata1 <= mem1[bus1.ram_rd_addr];
    end

    int checks = 0;
    int errors = 0;

    // reference state: contents as a queue, pointers as plain counters
    logic [7:0] q[$];
    int         wa = 0;
    int         ra = 0;
    bit         pv = 0;
    logic [7:0] pd = '0;
    bit         ovf = 0;
    bit         unf = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input bit wr, input bit rd, input bit rs);
        int  sz;
        bit  fullm, emptym, wacc, racc;
        @(negedge clk);
        bus0.wr_en = wr; bus1.wr_en = wr;
        bus0.rd_en = rd; bus1.rd_en = rd;
        rst   = rs;
        wdata = 8'($urandom);
        #1;
        sz     = q.size();
        fullm  = (sz == DEPTH);
        emptym = (sz == 0);
        wacc   = wr && !fullm && !rs;
        racc   = rd && !emptym && !rs;

        chk("count0", 32'(bus0.count), 32'(sz));
        chk("count1", 32'(bus1.count), 32'(sz));
        chk("full0", 32'(bus0.full), 32'(fullm));
        chk("full1", 32'(bus1.full), 32'(fullm));
        chk("empty0", 32'(bus0.empty), 32'(emptym));
        chk("empty1", 32'(bus1.empty), 32'(emptym));
        chk("afull0", 32'(bus0.almost_full), 32'(sz >= DEPTH - 2));
        chk("aempty0", 32'(bus0.almost_empty), 32'(sz <= 2));
        chk("afull1", 32'(bus1.almost_full), 32'(sz >= DEPTH - 2));
        chk("aempty1", 32'(bus1.almost_empty), 32'(sz <= 2));
        chk("ram_wr_en0", 32'(bus0.ram_wr_en), 32'(wacc));
        chk("ram_wr_en1", 32'(bus1.ram_wr_en), 32'(wacc));
        chk("wr_addr0", 32'(bus0.ram_wr_addr), 32'(wa));
        chk("rd_addr0", 32'(bus0.ram_rd_addr), 32'(ra));
        chk("wr_addr1", 32'(bus1.ram_wr_addr), 32'(wa));
        chk("rd_addr1", 32'(bus1.ram_rd_addr), 32'(ra));
        chk("rd_valid0", 32'(bus0.rd_valid), 32'(racc));
        if (racc) chk("rd_data0", 32'(mem0[bus0.ram_rd_addr]), 32'(q[0]));
        chk("rd_valid1", 32'(bus1.rd_valid), 32'(pv));
        if (pv) chk("rd_data1", 32'(rdata1), 32'(pd));
`ifdef FIFO_CTRL_ERR_FLAG_EN
        chk("ovf0", 32'(bus0.overflow_err), 32'(ovf));
        chk("unf0", 32'(bus0.underflow_err), 32'(unf));
        chk("ovf1", 32'(bus1.overflow_err), 32'(ovf));
        chk("unf1", 32'(bus1.underflow_err), 32'(unf));
`endif

        if (rs) begin
            q.delete();
            wa = 0; ra = 0; pv = 0; ovf = 0; unf = 0;
        end else begin
            ovf = ovf | (wr && fullm);
            unf = unf | (rd && emptym);
            if (racc) begin
                pd = q.pop_front();
                ra = (ra + 1) % DEPTH;
            end
            pv = racc;
            if (wacc) begin
                q.push_back(wdata);
                wa = (wa + 1) % DEPTH;
            end
        end
    endtask

    typedef struct {
        bit wr;
        bit rd;
        bit rs;
        int cnt;
        bit emp;
        bit wen;
        bit rv0;
    } vec_t;

    vec_t vt[8];

    initial begin
        vt[0] = '{1, 1, 0, 0, 1, 1, 0};
        vt[1] = '{1, 0, 0, 1, 0, 1, 0};
        vt[2] = '{0, 1, 0, 2, 0, 0, 1};
        vt[3] = '{1, 1, 0, 1, 0, 1, 1};
        vt[4] = '{0, 1, 0, 1, 0, 0, 1};
        vt[5] = '{0, 1, 0, 0, 1, 0, 0};
        vt[6] = '{1, 0, 1, 0, 1, 0, 0};
        vt[7] = '{0, 0, 0, 0, 1, 0, 0};

        bus0.wr_en = 0; bus1.wr_en = 0;
        bus0.rd_en = 0; bus1.rd_en = 0;
        wdata = '0;
        rst   = 1;
        repeat (2) @(posedge clk);

        // reset state
        step(0, 0, 0);
        chk("rst_empty", 32'(bus0.empty), 32'd1);
        chk("rst_count", 32'(bus1.count), 32'd0);
        chk("rst_rv1", 32'(bus1.rd_valid), 32'd0);

        // directed vector table
        for (int i = 0; i < 8; i++) begin
            step(vt[i].wr, vt[i].rd, vt[i].rs);
            chk($sformatf("vec%0d_count", i), 32'(bus0.count), 32'(vt[i].cnt));
            chk($sformatf("vec%0d_empty", i), 32'(bus0.empty), 32'(vt[i].emp));
            chk($sformatf("vec%0d_wen", i), 32'(bus0.ram_wr_en), 32'(vt[i].wen));
            chk($sformatf("vec%0d_rv0", i), 32'(bus0.rd_valid), 32'(vt[i].rv0));
        end

        // fill to full
        for (int i = 0; i < 16; i++) step(1, 0, 0);
        step(0, 0, 0);
        chk("fill_full", 32'(bus1.full), 32'd1);
        chk("fill_count", 32'(bus1.count), 32'd16);
        chk("fill_waddr", 32'(bus1.ram_wr_addr), 32'd0);

        // drain to empty
        for (int i = 0; i < 16; i++) step(0, 1, 0);
        step(0, 0, 0);
        chk("drain_empty", 32'(bus1.empty), 32'd1);
        chk("drain_raddr", 32'(bus1.ram_rd_addr), 32'd0);

        // steady push/pop at count 5
        for (int i = 0; i < 5; i++) step(1, 0, 0);
        for (int i = 0; i < 40; i++) step(1, 1, 0);
        step(0, 0, 0);
        chk("pp_count", 32'(bus0.count), 32'd5);

        // both requests while full, then while empty
        for (int i = 0; i < 11; i++) step(1, 0, 0);
        step(1, 1, 0);
        chk("full_both_wen", 32'(bus0.ram_wr_en), 32'd0);
        chk("full_both_rv0", 32'(bus0.rd_valid), 32'd1);
        step(0, 0, 0);
        chk("full_both_count", 32'(bus0.count), 32'd15);
        for (int i = 0; i < 15; i++) step(0, 1, 0);
        step(1, 1, 0);
        chk("empty_both_rv0", 32'(bus0.rd_valid), 32'd0);
        step(0, 0, 0);
        chk("empty_both_count", 32'(bus0.count), 32'd1);

        // reset mid-stream at count 9
        for (int i = 0; i < 8; i++) step(1, 0, 0);
        step(1, 0, 1);
        chk("rst_mid_wen", 32'(bus0.ram_wr_en), 32'd0);
        step(0, 0, 0);
        chk("rst_mid_count", 32'(bus0.count), 32'd0);
        chk("rst_mid_empty", 32'(bus1.empty), 32'd1);
        chk("rst_mid_rv1", 32'(bus1.rd_valid), 32'd0);

`ifdef FIFO_CTRL_ERR_FLAG_EN
        step(0, 1, 0);
        step(0, 0, 0);
        chk("unf_set", 32'(bus0.underflow_err), 32'd1);
        for (int i = 0; i < 16; i++) step(1, 0, 0);
        chk("unf_held", 32'(bus1.underflow_err), 32'd1);
        step(1, 0, 0);
        step(0, 0, 0);
        chk("ovf_set", 32'(bus0.overflow_err), 32'd1);
        step(0, 0, 1);
        step(0, 0, 0);
        chk("err_clr", 32'(bus0.overflow_err | bus0.underflow_err), 32'd0);
`endif

        // randomized traffic with shifting fill bias and rare resets
        for (int ph = 0; ph < 6; ph++) begin
            int pw;
            pw = (ph % 3 == 0) ? 75 : ((ph % 3 == 1) ? 25 : 50);
            for (int i = 0; i < 500; i++)
                step($urandom_range(99) < pw, $urandom_range(99) < (100 - pw),
                     $urandom_range(199) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
